// File: rtl/dist2jump_slew.sv
// Distance sample -> saturated NCO phase-increment target, with a slew-limited output increment.
// Build option DIST2JUMP_AVG_EN inserts a 4-tap moving average ahead of the multiplier.
module dist2jump_slew #(
  parameter int unsigned WIDTHIN  = 22,
  parameter int unsigned WIDTHOUT = 26,
  parameter int unsigned DECIMAL  = 16,
  parameter int unsigned SCALE    = 925,
  parameter int unsigned OFFSET   = 385528,
  parameter int unsigned MAX_STEP = 4096,
  parameter int unsigned SW_SHIFT = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [WIDTHIN-1:0]   in,
  input  logic                 test_mode,
  input  logic [9:0]           SW,
  input  logic                 tick,
  output logic [WIDTHOUT-1:0]  out,
  output logic [WIDTHOUT-1:0]  target,
  output logic [2*WIDTHIN-1:0] large_jump,
  output logic                 settled
);

  localparam int unsigned PW = 2 * WIDTHIN;
  localparam logic [WIDTHOUT-1:0] OFF_W   = WIDTHOUT'(OFFSET);
  localparam logic [WIDTHOUT-1:0] STEP_W  = WIDTHOUT'(MAX_STEP);
  localparam logic [PW-1:0]       SCALE_W = PW'(SCALE);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] RAMP_UP   = 2'd1;
  localparam logic [1:0] RAMP_DOWN = 2'd2;

  logic [WIDTHIN-1:0] s1_in;
  logic               s1_en;

`ifdef DIST2JUMP_AVG_EN
  localparam int STAGES = 2;

  logic [3:0][WIDTHIN-1:0] hist;
  logic                    primed;
  logic [WIDTHIN+1:0]      hist_sum;

  // First accepted sample after reset fills every tap so the average starts flat.
  always_ff @(posedge clk) begin
    if (reset) begin
      hist   <= '0;
      primed <= 1'b0;
    end else if (in_valid) begin
      primed <= 1'b1;
      if (!primed) hist <= {4{in}};
      else         hist <= {hist[2:0], in};
    end
  end

  assign hist_sum = (WIDTHIN+2)'(hist[0]) + (WIDTHIN+2)'(hist[1])
                  + (WIDTHIN+2)'(hist[2]) + (WIDTHIN+2)'(hist[3]);
  assign s1_in    = WIDTHIN'(hist_sum >> 2);
`else
  localparam int STAGES = 1;

  assign s1_in = in;
`endif

  logic [STAGES:1] vld_pipe;

`ifdef DIST2JUMP_AVG_EN
  assign s1_en = vld_pipe[1];
`else
  assign s1_en = in_valid;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe   <= '0;
      large_jump <= '0;
    end else begin
      vld_pipe[1] <= in_valid;
      for (int k = 2; k <= STAGES; k++) vld_pipe[k] <= vld_pipe[k-1];
      if (s1_en) large_jump <= SCALE_W * PW'(s1_in);
    end
  end

  // Stage 2: drop fraction bits, add offset, clamp on carry rather than wrap.
  logic [WIDTHOUT-1:0] scaled;
  logic [WIDTHOUT:0]   sum;
  logic [WIDTHOUT-1:0] sat_tgt;
  logic [WIDTHOUT-1:0] sw_tgt;

  assign scaled  = large_jump[WIDTHOUT+DECIMAL-1:DECIMAL];
  assign sum     = {1'b0, scaled} + {1'b0, OFF_W};
  assign sat_tgt = sum[WIDTHOUT] ? '1 : sum[WIDTHOUT-1:0];
  assign sw_tgt  = WIDTHOUT'(SW) << SW_SHIFT;

  function automatic logic [WIDTHOUT-1:0] clamp_step(input logic [WIDTHOUT-1:0] d);
    if (MAX_STEP == 0 || d < STEP_W) return d;
    return STEP_W;
  endfunction

  logic [1:0]          state, state_nx;
  logic [WIDTHOUT-1:0] out_nx, target_nx;

  // Direction is registered from this cycle's compare; the step also re-checks order so
  // a target that crossed out since the last compare can never cause an overshoot.
  always_comb begin
    state_nx  = IDLE;
    out_nx    = out;
    target_nx = target;
    if (out < target)      state_nx = RAMP_UP;
    else if (out > target) state_nx = RAMP_DOWN;
    if (tick && state == RAMP_UP && out < target)
      out_nx = out + clamp_step(target - out);
    else if (tick && state == RAMP_DOWN && out > target)
      out_nx = out - clamp_step(out - target);
    if (test_mode)          target_nx = sw_tgt;
    else if (vld_pipe[STAGES]) target_nx = sat_tgt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      out     <= OFF_W;
      target  <= OFF_W;
      settled <= 1'b1;
    end else begin
      state   <= state_nx;
      out     <= out_nx;
      target  <= target_nx;
      settled <= (out_nx == target_nx);
    end
  end

endmodule
